video_mux_sched: RTL and testbench
==================================

VIDEO_MUX_SCHED -- requirements
Module: video_mux_sched

Interface
REQ-001 Parameter FRAME_LINES, default 480: lines (tlast beats) per frame.
REQ-002 Parameter TIMEOUT_CYCLES, default 1048576: maximum cycles a pending switch waits for end-of-frame.
REQ-003 Parameter DEFAULT_SEL, default 2'd0: mux_V value after reset.
REQ-004 The block SHALL use one clock, and reset SHALL be synchronous and active-low.
REQ-005 Ports SHALL be as follows:
- clk  in  1  sole clock
- ap_rst_n  in  1  synchronous active-low reset
- sel_req  in  2  requested video mux select
- sel_req_valid  in  1  request valid
- sel_req_ready  out  1  request accepted when valid&ready
- strm_tvalid  in  1  monitored video stream valid
- strm_tready  in  1  monitored video stream ready
- strm_tuser  in  1  start-of-frame marker
- strm_tlast  in  1  end-of-line marker
- mux_V  out  2  registered select driven to the video datapath
- switch_done  out  1  one-cycle pulse when a request completes
- frame_err  out  1  sticky short-frame flag
- timeout_err  out  1  sticky forced-switch flag
- err_clr  in  1  clears both sticky flags
- frame_cnt  out  16  count of completed frames, wraps

Function
REQ-006 A beat SHALL be defined as strm_tvalid & strm_tready; tuser and tlast SHALL be sampled only on beats.
REQ-007 line_cnt (internal) SHALL load 0 on a tuser beat, load 1 if that beat also has tlast, and otherwise increment on each tlast beat.
REQ-008 The synced flag SHALL be cleared by reset and set by the first tuser beat; EOF SHALL be detected only while synced.
REQ-009 EOF SHALL be a tlast beat with line_cnt == FRAME_LINES-1; on EOF, line_cnt SHALL return to 0.
REQ-010 On EOF, frame_cnt SHALL increment by 1 modulo 2^16.
REQ-011 On a tuser beat with line_cnt != 0 while synced, frame_err SHALL be set (short frame), and line_cnt SHALL resynchronise per REQ-007.
REQ-012 The state machine SHALL have two states: RUN and PEND.
REQ-013 In RUN, sel_req_ready SHALL be 1; in PEND, it SHALL be 0.
REQ-014 RUN, accepted request with sel_req == mux_V: the block SHALL stay in RUN and pulse switch_done on the next cycle.
REQ-015 RUN, accepted request with sel_req != mux_V: the block SHALL latch sel_req into pend_sel, clear tmo_cnt, and go to PEND.
REQ-016 A request accepted in the same cycle as an EOF beat SHALL NOT use that EOF; it SHALL wait for the next EOF.
REQ-017 PEND, EOF in cycle N: in cycle N+1, mux_V SHALL equal pend_sel, switch_done SHALL be 1, and the state SHALL be RUN (sel_req_ready=1).
REQ-018 In PEND without EOF, tmo_cnt SHALL increment each cycle.
REQ-019 When tmo_cnt reaches TIMEOUT_CYCLES-1 with no EOF, the next cycle SHALL apply pend_sel, pulse switch_done, set timeout_err, and return to RUN.
REQ-020 If EOF and timeout occur in the same cycle, the switch SHALL be treated as EOF (timeout_err not set).
REQ-021 mux_V SHALL change only per REQ-017/REQ-019 and never mid-frame otherwise.
REQ-022 err_clr SHALL clear frame_err and timeout_err; a set condition in the same cycle SHALL win (flag remains 1).
REQ-023 switch_done SHALL never be high for two consecutive cycles.

Reset
REQ-024 While ap_rst_n=0 on a clk edge: mux_V=DEFAULT_SEL, state=RUN, synced=0, line_cnt=0, tmo_cnt=0, frame_cnt=0, switch_done=0, frame_err=0, timeout_err=0, sel_req_ready=0.
REQ-025 sel_req_ready SHALL rise in the first cycle after reset release.
REQ-026 Reset in PEND SHALL discard the pending request, with no switch_done pulse.

Verification (FRAME_LINES=4, TIMEOUT_CYCLES=64, DEFAULT_SEL=0)
REQ-027 Request sel=2 mid-frame, frame continues -> mux_V stays 0 until the cycle after the 4th tlast beat, then mux_V=2 with switch_done pulsed once, and frame_cnt +1.
REQ-028 Request sel=0 while mux_V=0 -> no state change, switch_done pulses on the next cycle, and ready stays 1.
REQ-029 Request sel=1, then strm_tvalid held 0 -> after 64 PEND cycles, mux_V=1, timeout_err=1, and switch_done pulses; err_clr then clears timeout_err.
REQ-030 tuser beat after only 2 lines -> frame_err=1, no EOF counted, and the next full 4-line frame increments frame_cnt.
REQ-031 Request accepted on the same cycle as an EOF beat -> switch occurs only after the following frame's EOF.
REQ-032 ap_rst_n=0 asserted while in PEND -> all outputs per REQ-024, with no switch_done pulse.

Source files
------------

// File: rtl/video_mux_sched.sv
// Video mux select scheduler: defers select changes to end-of-frame of the monitored
// stream, forcing the switch after TIMEOUT_CYCLES if no frame boundary shows up.
module video_mux_sched #(
  parameter int         FRAME_LINES    = 480,
  parameter int         TIMEOUT_CYCLES = 1048576,
  parameter logic [1:0] DEFAULT_SEL    = 2'd0
) (
  input  logic        clk,
  input  logic        ap_rst_n,
  input  logic [1:0]  sel_req,
  input  logic        sel_req_valid,
  output logic        sel_req_ready,
  input  logic        strm_tvalid,
  input  logic        strm_tready,
  input  logic        strm_tuser,
  input  logic        strm_tlast,
  output logic [1:0]  mux_V,
  output logic        switch_done,
  output logic        frame_err,
  output logic        timeout_err,
  input  logic        err_clr,
  output logic [15:0] frame_cnt
);

  // state | meaning
  // RUN   | idle, requests accepted; same-select requests complete immediately
  // PEND  | new select latched, waiting for end-of-frame or timeout
  typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_t;

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0]   FL_LAST  = 16'(FRAME_LINES - 1);

  state_t        state_q, state_d;
  logic [1:0]    mux_q, mux_d, pend_sel_q, pend_sel_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [15:0]   line_cnt_q, line_cnt_d, frame_cnt_q, frame_cnt_d;
  logic          synced_q, synced_d, alive_q;
  logic          done_q, done_d, defer_q, defer_d;
  logic          ferr_q, ferr_d, terr_q, terr_d;
  logic          beat, sof_beat, tl_beat, eof, acc, sw_evt, tmo_evt;

  assign beat     = strm_tvalid & strm_tready;
  assign sof_beat = beat & strm_tuser;
  assign tl_beat  = beat & strm_tlast;
  assign eof      = tl_beat & ~strm_tuser & synced_q & (line_cnt_q == FL_LAST);
  assign acc      = sel_req_valid & sel_req_ready;

  always_ff @(posedge clk) begin
    if (!ap_rst_n) state_q <= RUN;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    mux_d      = mux_q;
    pend_sel_d = pend_sel_q;
    tmo_cnt_d  = tmo_cnt_q;
    sw_evt     = 1'b0;
    tmo_evt    = 1'b0;
    case (state_q)
      RUN: begin
        if (acc && sel_req == mux_q) begin
          sw_evt = 1'b1;
        end else if (acc) begin
          pend_sel_d = sel_req;
          tmo_cnt_d  = '0;
          state_d    = PEND;
        end
      end
      PEND: begin
        if (eof || tmo_cnt_q == TMO_LAST) begin
          mux_d   = pend_sel_q;
          sw_evt  = 1'b1;
          tmo_evt = ~eof;
          state_d = RUN;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // A completion landing right after a pulse is held one cycle so pulses never abut.
  always_comb begin
    sel_req_ready = (state_q == RUN) & alive_q;
    done_d        = (sw_evt | defer_q) & ~done_q;
    defer_d       = (sw_evt | defer_q) & done_q;
    ferr_d        = (sof_beat & synced_q & (line_cnt_q != 16'd0)) | (ferr_q & ~err_clr);
    terr_d        = tmo_evt | (terr_q & ~err_clr);
  end

  always_comb begin
    line_cnt_d  = line_cnt_q;
    frame_cnt_d = frame_cnt_q;
    synced_d    = synced_q | sof_beat;
    if (sof_beat) begin
      line_cnt_d = strm_tlast ? 16'd1 : 16'd0;
    end else if (eof) begin
      line_cnt_d  = 16'd0;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end else if (tl_beat) begin
      line_cnt_d = line_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!ap_rst_n) begin
      mux_q       <= DEFAULT_SEL;
      pend_sel_q  <= DEFAULT_SEL;
      tmo_cnt_q   <= '0;
      line_cnt_q  <= '0;
      frame_cnt_q <= '0;
      synced_q    <= 1'b0;
      alive_q     <= 1'b0;
      done_q      <= 1'b0;
      defer_q     <= 1'b0;
      ferr_q      <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      mux_q       <= mux_d;
      pend_sel_q  <= pend_sel_d;
      tmo_cnt_q   <= tmo_cnt_d;
      line_cnt_q  <= line_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      synced_q    <= synced_d;
      alive_q     <= 1'b1;
      done_q      <= done_d;
      defer_q     <= defer_d;
      ferr_q      <= ferr_d;
      terr_q      <= terr_d;
    end
  end

  assign mux_V       = mux_q;
  assign switch_done = done_q;
  assign frame_err   = ferr_q;
  assign timeout_err = terr_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_video_mux_sched.sv
// Directed bench for video_mux_sched with FRAME_LINES=4, TIMEOUT_CYCLES=64.
module tb_video_mux_sched;

  logic        clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic [1:0]  sel_req = 2'd0;
  logic        sel_req_valid = 1'b0;
  logic        sel_req_ready;
  logic        strm_tvalid = 1'b0;
  logic        strm_tready = 1'b1;
  logic        strm_tuser = 1'b0;
  logic        strm_tlast = 1'b0;
  logic [1:0]  mux_V;
  logic        switch_done;
  logic        frame_err;
  logic        timeout_err;
  logic        err_clr = 1'b0;
  logic [15:0] frame_cnt;

  int n_chk = 0;
  int n_pass = 0;

  video_mux_sched #(.FRAME_LINES(4), .TIMEOUT_CYCLES(64), .DEFAULT_SEL(2'd0)) dut (
    .clk(clk), .ap_rst_n(ap_rst_n),
    .sel_req(sel_req), .sel_req_valid(sel_req_valid), .sel_req_ready(sel_req_ready),
    .strm_tvalid(strm_tvalid), .strm_tready(strm_tready),
    .strm_tuser(strm_tuser), .strm_tlast(strm_tlast),
    .mux_V(mux_V), .switch_done(switch_done), .frame_err(frame_err),
    .timeout_err(timeout_err), .err_clr(err_clr), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock with the given stream beat; one-shot inputs are dropped afterwards.
  task automatic cyc(input logic v, input logic u, input logic l);
    strm_tvalid = v;
    strm_tuser  = u;
    strm_tlast  = l;
    @(posedge clk);
    #1;
    strm_tvalid   = 1'b0;
    strm_tuser    = 1'b0;
    strm_tlast    = 1'b0;
    sel_req_valid = 1'b0;
    err_clr       = 1'b0;
  endtask

  task automatic request(input logic [1:0] s);
    sel_req       = s;
    sel_req_valid = 1'b1;
  endtask

  initial begin
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("rst_mux", 32'(mux_V), 0);
    chk("rst_ready", 32'(sel_req_ready), 0);
    chk("rst_done", 32'(switch_done), 0);
    chk("rst_errs", {frame_err, timeout_err}, 0);
    chk("rst_fcnt", 32'(frame_cnt), 0);
    ap_rst_n = 1'b1;
    cyc(0, 0, 0);
    chk("ready_after_rst", 32'(sel_req_ready), 1);

    // first frame syncs and counts
    cyc(1, 1, 0);
    repeat (4) cyc(1, 0, 1);
    chk("sync_frame_fcnt", 32'(frame_cnt), 1);

    // same-select request
    request(2'd0);
    cyc(0, 0, 0);
    chk("same_done", 32'(switch_done), 1);
    chk("same_ready", 32'(sel_req_ready), 1);
    chk("same_mux", 32'(mux_V), 0);
    cyc(0, 0, 0);
    chk("same_done_drop", 32'(switch_done), 0);

    // mid-frame switch to 2
    cyc(1, 1, 0);
    cyc(1, 0, 1);
    request(2'd2);
    cyc(0, 0, 0);
    chk("pend_ready", 32'(sel_req_ready), 0);
    cyc(1, 0, 1);
    cyc(1, 0, 1);
    chk("pend_mux_hold", 32'(mux_V), 0);
    chk("pend_no_done", 32'(switch_done), 0);
    cyc(1, 0, 1);
    chk("eof_mux", 32'(mux_V), 2);
    chk("eof_done", 32'(switch_done), 1);
    chk("eof_ready", 32'(sel_req_ready), 1);
    chk("eof_fcnt", 32'(frame_cnt), 2);
    cyc(0, 0, 0);
    chk("eof_done_once", 32'(switch_done), 0);

    // short frame
    cyc(1, 1, 0);
    cyc(1, 0, 1);
    cyc(1, 0, 1);
    cyc(1, 1, 0);
    chk("short_ferr", 32'(frame_err), 1);
    chk("short_fcnt", 32'(frame_cnt), 2);
    repeat (4) cyc(1, 0, 1);
    chk("resync_fcnt", 32'(frame_cnt), 3);
    err_clr = 1'b1;
    cyc(0, 0, 0);
    chk("ferr_clr", 32'(frame_err), 0);

    // request on the EOF beat waits a full frame
    cyc(1, 1, 0);
    repeat (3) cyc(1, 0, 1);
    request(2'd3);
    cyc(1, 0, 1);
    chk("eofreq_fcnt", 32'(frame_cnt), 4);
    chk("eofreq_mux", 32'(mux_V), 2);
    chk("eofreq_ready", 32'(sel_req_ready), 0);
    chk("eofreq_done", 32'(switch_done), 0);
    cyc(1, 1, 0);
    repeat (3) cyc(1, 0, 1);
    chk("eofreq_hold", 32'(mux_V), 2);
    cyc(1, 0, 1);
    chk("eofreq_switch", 32'(mux_V), 3);
    chk("eofreq_sdone", 32'(switch_done), 1);
    cyc(0, 0, 0);

    // timeout with a stalled stream
    request(2'd1);
    cyc(0, 0, 0);
    repeat (63) cyc(0, 0, 0);
    chk("tmo_hold_mux", 32'(mux_V), 3);
    chk("tmo_hold_err", 32'(timeout_err), 0);
    chk("tmo_hold_ready", 32'(sel_req_ready), 0);
    cyc(0, 0, 0);
    chk("tmo_mux", 32'(mux_V), 1);
    chk("tmo_err", 32'(timeout_err), 1);
    chk("tmo_done", 32'(switch_done), 1);
    chk("tmo_ready", 32'(sel_req_ready), 1);
    err_clr = 1'b1;
    cyc(0, 0, 0);
    chk("tmo_clr", 32'(timeout_err), 0);
    chk("tmo_done_once", 32'(switch_done), 0);

    // reset while pending
    request(2'd2);
    cyc(0, 0, 0);
    chk("rstp_pend", 32'(sel_req_ready), 0);
    ap_rst_n = 1'b0;
    cyc(0, 0, 0);
    chk("rstp_mux", 32'(mux_V), 0);
    chk("rstp_ready", 32'(sel_req_ready), 0);
    chk("rstp_done", 32'(switch_done), 0);
    chk("rstp_fcnt", 32'(frame_cnt), 0);
    ap_rst_n = 1'b1;
    cyc(0, 0, 0);
    chk("rstp_ready_up", 32'(sel_req_ready), 1);
    chk("rstp_no_done", 32'(switch_done), 0);
    chk("rstp_mux_after", 32'(mux_V), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
